// File: rtl/reorder_buffer_if.sv
// Shared ROB entry type and the dispatch / CDB / commit bundle of the reorder buffer.
package rob_pkg;
  localparam int ROB_IDX_W = 4;

  typedef struct packed {
    logic [31:0]          pc;
    logic [3:0]           itype;
    logic [4:0]           reg_dest;
    logic                 jalr;
    logic                 branch_pred;
    logic                 special;
    logic                 csr_valid_read;
    logic                 csr_valid_write;
    logic [11:0]          csr_write_select;
    logic [3:0]           ras_pointer;
    logic [ROB_IDX_W-1:0] ROB_number;
    logic [31:0]          value;
    logic [31:0]          destination;
    logic                 branch_result;
    logic                 exception;
    logic [7:0]           mcause;
  } rob_entry_t;
endpackage

interface reorder_buffer_if;
  import rob_pkg::*;

  logic                 alloc_en;
  rob_entry_t           alloc_entry;
  logic                 alloc_ready;
  logic [ROB_IDX_W-1:0] alloc_ROB;
  logic                 full;

  logic                 wb_valid;
  logic [ROB_IDX_W-1:0] wb_ROB;
  logic [31:0]          wb_value;
  logic [31:0]          wb_destination;
  logic                 wb_branch_result;
  logic                 wb_exception;
  logic [7:0]           wb_mcause;

  logic [ROB_IDX_W-1:0] src1_ROB;
  logic [ROB_IDX_W-1:0] src2_ROB;
  logic                 src1_ready;
  logic                 src2_ready;
  logic [31:0]          src1_value;
  logic [31:0]          src2_value;

  logic                 rd_en;
  logic                 flush;
  rob_entry_t           head;
  logic                 rob_head_ready;
  logic                 empty;
  logic [ROB_IDX_W:0]   count;

  modport master (
    output alloc_en, alloc_entry, alloc_ready,
    output wb_valid, wb_ROB, wb_value, wb_destination, wb_branch_result, wb_exception, wb_mcause,
    output src1_ROB, src2_ROB, rd_en, flush,
    input  alloc_ROB, full, src1_ready, src2_ready, src1_value, src2_value,
    input  head, rob_head_ready, empty, count
  );

  modport slave (
    input  alloc_en, alloc_entry, alloc_ready,
    input  wb_valid, wb_ROB, wb_value, wb_destination, wb_branch_result, wb_exception, wb_mcause,
    input  src1_ROB, src2_ROB, rd_en, flush,
    output alloc_ROB, full, src1_ready, src2_ready, src1_value, src2_value,
    output head, rob_head_ready, empty, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate, out-of-order writeback by tag,
// in-order commit from head, full squash on flush.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave bus
);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic full_w, empty_w, alloc_ok, deq_ok;

  assign full_w   = (count_q == (IDX_W+1)'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign alloc_ok = bus.alloc_en & ~full_w;
  assign deq_ok   = bus.rd_en & ~empty_w;

  // Next-state: writeback, then allocation, then dequeue (dequeue overrides a same-slot writeback).
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (bus.wb_valid && valid_q[bus.wb_ROB]) begin
      entries_d[bus.wb_ROB].value         = bus.wb_value;
      entries_d[bus.wb_ROB].destination   = bus.wb_destination;
      entries_d[bus.wb_ROB].branch_result = bus.wb_branch_result;
      entries_d[bus.wb_ROB].exception     = bus.wb_exception;
      entries_d[bus.wb_ROB].mcause        = bus.wb_mcause;
      ready_d[bus.wb_ROB]                 = 1'b1;
    end

    if (alloc_ok) begin
      entries_d[tail_q]               = bus.alloc_entry;
      entries_d[tail_q].ROB_number    = tail_q;
      entries_d[tail_q].value         = '0;
      entries_d[tail_q].destination   = '0;
      entries_d[tail_q].branch_result = 1'b0;
      entries_d[tail_q].exception     = 1'b0;
      entries_d[tail_q].mcause        = '0;
      valid_d[tail_q]                 = 1'b1;
      ready_d[tail_q]                 = bus.alloc_ready;
      tail_d                          = tail_q + 1'b1;
    end

    if (deq_ok) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    case ({alloc_ok, deq_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Payloads are left stale on flush; only the bookkeeping is squashed.
    if (bus.flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; contents only matter while the slot is valid.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign bus.alloc_ROB      = tail_q;
  assign bus.full           = full_w;
  assign bus.empty          = empty_w;
  assign bus.count          = count_q;
  assign bus.head           = empty_w ? '0 : entries_q[head_q];
  assign bus.rob_head_ready = ~empty_w & ready_q[head_q];

  // Operand lookup with same-cycle bypass from the CDB.
  always_comb begin
    bus.src1_ready = 1'b0;
    bus.src1_value = '0;
    if (bus.wb_valid && (bus.wb_ROB == bus.src1_ROB)) begin
      bus.src1_ready = 1'b1;
      bus.src1_value = bus.wb_value;
    end else if (valid_q[bus.src1_ROB]) begin
      bus.src1_ready = ready_q[bus.src1_ROB];
      bus.src1_value = entries_q[bus.src1_ROB].value;
    end
  end

  // Second operand port, same rules as the first.
  always_comb begin
    bus.src2_ready = 1'b0;
    bus.src2_value = '0;
    if (bus.wb_valid && (bus.wb_ROB == bus.src2_ROB)) begin
      bus.src2_ready = 1'b1;
      bus.src2_value = bus.wb_value;
    end else if (valid_q[bus.src2_ROB]) begin
      bus.src2_ready = ready_q[bus.src2_ROB];
      bus.src2_value = entries_q[bus.src2_ROB].value;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// against a program-order queue model.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if bus ();

  reorder_buffer #(.DEPTH(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    rob_entry_t e;
    logic       rdy;
  } mrec_t;

  mrec_t mq[$];
  int    m_tail;
  int    vectors;
  int    miscompares;

  // Model: the buffer is simply the list of in-flight instructions, oldest first.
  task automatic model_edge();
    bit    do_alloc;
    bit    do_deq;
    mrec_t r;
    if (rst || bus.flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      do_alloc = bus.alloc_en && (mq.size() < 16);
      do_deq   = bus.rd_en && (mq.size() > 0);
      if (bus.wb_valid)
        foreach (mq[i])
          if (mq[i].e.ROB_number == bus.wb_ROB) begin
            mq[i].e.value         = bus.wb_value;
            mq[i].e.destination   = bus.wb_destination;
            mq[i].e.branch_result = bus.wb_branch_result;
            mq[i].e.exception     = bus.wb_exception;
            mq[i].e.mcause        = bus.wb_mcause;
            mq[i].rdy             = 1'b1;
          end
      if (do_deq) void'(mq.pop_front());
      if (do_alloc) begin
        r.e               = bus.alloc_entry;
        r.e.ROB_number    = 4'(m_tail);
        r.e.value         = '0;
        r.e.destination   = '0;
        r.e.branch_result = 1'b0;
        r.e.exception     = 1'b0;
        r.e.mcause        = '0;
        r.rdy             = bus.alloc_ready;
        mq.push_back(r);
        m_tail = (m_tail + 1) % 16;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_en         = 1'b0;
    bus.alloc_entry      = '0;
    bus.alloc_ready      = 1'b0;
    bus.wb_valid         = 1'b0;
    bus.wb_ROB           = '0;
    bus.wb_value         = '0;
    bus.wb_destination   = '0;
    bus.wb_branch_result = 1'b0;
    bus.wb_exception     = 1'b0;
    bus.wb_mcause        = '0;
    bus.src1_ROB         = '0;
    bus.src2_ROB         = '0;
    bus.rd_en            = 1'b0;
    bus.flush            = 1'b0;
  endtask

  function automatic rob_entry_t rand_entry();
    rob_entry_t e;
    e.pc               = $urandom;
    e.itype            = 4'($urandom);
    e.reg_dest         = 5'($urandom);
    e.jalr             = 1'($urandom);
    e.branch_pred      = 1'($urandom);
    e.special          = 1'($urandom);
    e.csr_valid_read   = 1'($urandom);
    e.csr_valid_write  = 1'($urandom);
    e.csr_write_select = 12'($urandom);
    e.ras_pointer      = 4'($urandom);
    e.ROB_number       = 4'($urandom);
    e.value            = $urandom;
    e.destination      = $urandom;
    e.branch_result    = 1'($urandom);
    e.exception        = 1'($urandom);
    e.mcause           = 8'($urandom);
    return e;
  endfunction

  function automatic void model_lookup(input logic [3:0] tag, output logic rdy, output logic [31:0] val);
    rdy = 1'b0;
    val = '0;
    if (bus.wb_valid && bus.wb_ROB == tag) begin
      rdy = 1'b1;
      val = bus.wb_value;
    end else
      foreach (mq[i])
        if (mq[i].e.ROB_number == tag) begin
          rdy = mq[i].rdy;
          val = mq[i].e.value;
        end
  endfunction

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_one(input logic rdy);
    bus.alloc_en    = 1'b1;
    bus.alloc_entry = rand_entry();
    bus.alloc_ready = rdy;
    tick();
    bus.alloc_en    = 1'b0;
    bus.alloc_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.src1_ROB = 4'd3;
    bus.src2_ROB = 4'd0;
    #1;
    vectors++; if (bus.head !== '0) begin miscompares++; $display("FAIL reset_head: got %h expected 0", bus.head); end
    vectors++; if (bus.rob_head_ready !== 1'b0) begin miscompares++; $display("FAIL reset_head_ready: got %b expected 0", bus.rob_head_ready); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    vectors++; if (bus.count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    vectors++; if (bus.alloc_ROB !== 4'd0) begin miscompares++; $display("FAIL reset_alloc_rob: got %0d expected 0", bus.alloc_ROB); end
    vectors++; if ({bus.src1_ready, bus.src1_value} !== 33'd0) begin miscompares++; $display("FAIL reset_src1: got %b/%h expected 0/0", bus.src1_ready, bus.src1_value); end
    vectors++; if ({bus.src2_ready, bus.src2_value} !== 33'd0) begin miscompares++; $display("FAIL reset_src2: got %b/%h expected 0/0", bus.src2_ready, bus.src2_value); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.alloc_en    = 1'b1;
      bus.alloc_entry = rand_entry();
      #1;
      vectors++; if (bus.alloc_ROB !== 4'(i)) begin miscompares++; $display("FAIL fill_tag: got %0d expected %0d", bus.alloc_ROB, i); end
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL fill_not_full: got %b expected 0 at %0d", bus.full, i); end
      tick();
    end
    #1;
    vectors++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin miscompares++; $display("FAIL fill_full: got full=%b count=%0d expected 1/16", bus.full, bus.count); end
    bus.alloc_entry = rand_entry();
    tick();
    bus.alloc_en = 1'b0;
    #1;
    vectors++; if (bus.count !== 5'd16) begin miscompares++; $display("FAIL fill_17th_ignored: got %0d expected 16", bus.count); end
    vectors++; if (bus.rob_head_ready !== 1'b0) begin miscompares++; $display("FAIL fill_head_ready: got %b expected 0", bus.rob_head_ready); end
    vectors++; if (bus.head.ROB_number !== 4'd0) begin miscompares++; $display("FAIL fill_head_tag: got %0d expected 0", bus.head.ROB_number); end
  endtask

  task automatic test_inorder_commit();
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(1'b0);
    bus.wb_valid = 1'b1; bus.wb_ROB = 4'd1; bus.wb_value = 32'h11;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    vectors++; if (bus.rob_head_ready !== 1'b0) begin miscompares++; $display("FAIL commit_young_wb: got %b expected 0", bus.rob_head_ready); end
    bus.wb_valid = 1'b1; bus.wb_ROB = 4'd0; bus.wb_value = 32'hA5;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    vectors++; if (bus.rob_head_ready !== 1'b1 || bus.head.value !== 32'hA5) begin miscompares++; $display("FAIL commit_head_wb: got rdy=%b val=%h expected 1/a5", bus.rob_head_ready, bus.head.value); end
    bus.rd_en = 1'b1;
    tick();
    #1;
    vectors++; if (bus.head.ROB_number !== 4'd1 || bus.rob_head_ready !== 1'b1 || bus.head.value !== 32'h11) begin miscompares++; $display("FAIL commit_second: got tag=%0d rdy=%b val=%h expected 1/1/11", bus.head.ROB_number, bus.rob_head_ready, bus.head.value); end
    tick();
    bus.rd_en = 1'b0;
    #1;
    vectors++; if (bus.head.ROB_number !== 4'd2 || bus.rob_head_ready !== 1'b0 || bus.count !== 5'd1) begin miscompares++; $display("FAIL commit_third: got tag=%0d rdy=%b count=%0d expected 2/0/1", bus.head.ROB_number, bus.rob_head_ready, bus.count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) alloc_one(1'b0);
    bus.rd_en = 1'b1; bus.alloc_en = 1'b1; bus.alloc_entry = rand_entry();
    tick();
    bus.rd_en = 1'b0;
    #1;
    vectors++; if (bus.count !== 5'd15 || bus.full !== 1'b0) begin miscompares++; $display("FAIL wrap_deq_only: got count=%0d full=%b expected 15/0", bus.count, bus.full); end
    vectors++; if (bus.alloc_ROB !== 4'd0) begin miscompares++; $display("FAIL wrap_tail: got %0d expected 0", bus.alloc_ROB); end
    vectors++; if (bus.head.ROB_number !== 4'd1) begin miscompares++; $display("FAIL wrap_head: got %0d expected 1", bus.head.ROB_number); end
    tick();
    bus.alloc_en = 1'b0;
    #1;
    vectors++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.alloc_ROB !== 4'd1) begin miscompares++; $display("FAIL wrap_refill: got count=%0d full=%b tail=%0d expected 16/1/1", bus.count, bus.full, bus.alloc_ROB); end
  endtask

  task automatic test_bypass();
    logic [31:0] v, w;
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one(1'b0);
    v = $urandom; w = $urandom;
    bus.wb_valid = 1'b1; bus.wb_ROB = 4'd5; bus.wb_value = v;
    bus.src1_ROB = 4'd5; bus.src2_ROB = 4'd3;
    #1;
    vectors++; if (bus.src1_ready !== 1'b1 || bus.src1_value !== v) begin miscompares++; $display("FAIL bypass_src1: got %b/%h expected 1/%h", bus.src1_ready, bus.src1_value, v); end
    vectors++; if (bus.src2_ready !== 1'b0 || bus.src2_value !== 32'd0) begin miscompares++; $display("FAIL bypass_src2_pending: got %b/%h expected 0/0", bus.src2_ready, bus.src2_value); end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    vectors++; if (bus.src1_ready !== 1'b1 || bus.src1_value !== v) begin miscompares++; $display("FAIL bypass_stored: got %b/%h expected 1/%h", bus.src1_ready, bus.src1_value, v); end
    bus.wb_valid = 1'b1; bus.wb_ROB = 4'd9; bus.wb_value = w;
    tick();
    bus.wb_valid = 1'b0; bus.src2_ROB = 4'd9;
    #1;
    vectors++; if (bus.src2_ready !== 1'b0 || bus.src2_value !== 32'd0 || bus.count !== 5'd6) begin miscompares++; $display("FAIL wb_free_tag: got %b/%h count=%0d expected 0/0/6", bus.src2_ready, bus.src2_value, bus.count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(1'b0);
    bus.wb_valid = 1'b1; bus.wb_ROB = 4'd2; bus.wb_exception = 1'b1; bus.wb_mcause = 8'd2;
    tick();
    bus.wb_valid = 1'b0; bus.wb_exception = 1'b0; bus.wb_mcause = '0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    vectors++; if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.alloc_ROB !== 4'd0) begin miscompares++; $display("FAIL flush_state: got empty=%b count=%0d tail=%0d expected 1/0/0", bus.empty, bus.count, bus.alloc_ROB); end
    alloc_one(1'b0);
    #1;
    vectors++; if (bus.head.ROB_number !== 4'd0 || bus.head.exception !== 1'b0 || bus.head.mcause !== 8'd0) begin miscompares++; $display("FAIL flush_realloc: got tag=%0d exc=%b mcause=%0d expected 0/0/0", bus.head.ROB_number, bus.head.exception, bus.head.mcause); end
  endtask

  task automatic test_ecall_and_midreset();
    do_reset();
    alloc_one(1'b1);
    #1;
    vectors++; if (bus.rob_head_ready !== 1'b1 || bus.count !== 5'd1) begin miscompares++; $display("FAIL ecall_ready: got rdy=%b count=%0d expected 1/1", bus.rob_head_ready, bus.count); end
    for (int i = 0; i < 3; i++) alloc_one(1'b1);
    bus.rd_en = 1'b1; bus.alloc_en = 1'b1; bus.alloc_entry = rand_entry();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bus.src1_ROB = 4'd1;
    #1;
    vectors++; if (bus.head !== '0 || bus.rob_head_ready !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 5'd0 || bus.alloc_ROB !== 4'd0 || bus.src1_ready !== 1'b0 || bus.src1_value !== 32'd0) begin
      miscompares++; $display("FAIL midreset: got rdy=%b empty=%b full=%b count=%0d tail=%0d src1=%b/%h", bus.rob_head_ready, bus.empty, bus.full, bus.count, bus.alloc_ROB, bus.src1_ready, bus.src1_value);
    end
  endtask

  task automatic test_random();
    rob_entry_t  eh;
    logic        r1, r2;
    logic [31:0] v1, v2;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.flush            = ($urandom_range(0, 59) == 0);
      bus.alloc_en         = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.rd_en            = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.alloc_entry      = rand_entry();
      bus.alloc_ready      = ($urandom_range(0, 5) == 0);
      bus.wb_valid         = 1'($urandom);
      bus.wb_ROB           = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].e.ROB_number : 4'($urandom);
      bus.wb_value         = $urandom;
      bus.wb_destination   = $urandom;
      bus.wb_branch_result = 1'($urandom);
      bus.wb_exception     = ($urandom_range(0, 7) == 0);
      bus.wb_mcause        = 8'($urandom);
      bus.src1_ROB         = (mq.size() > 0 && $urandom_range(0, 2) != 0) ? mq[$urandom_range(0, mq.size() - 1)].e.ROB_number : 4'($urandom);
      bus.src2_ROB         = ($urandom_range(0, 3) == 0) ? bus.wb_ROB : 4'($urandom);
      #1;
      eh = (mq.size() > 0) ? mq[0].e : '0;
      model_lookup(bus.src1_ROB, r1, v1);
      model_lookup(bus.src2_ROB, r2, v2);
      vectors++; if (bus.head !== eh) begin miscompares++; $display("FAIL rnd_head @%0d: got %h expected %h", i, bus.head, eh); end
      vectors++; if (bus.rob_head_ready !== (mq.size() > 0 && mq[0].rdy)) begin miscompares++; $display("FAIL rnd_head_ready @%0d: got %b", i, bus.rob_head_ready); end
      vectors++; if (bus.count !== 5'(mq.size()) || bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == 16)) begin miscompares++; $display("FAIL rnd_count @%0d: got %0d/%b/%b expected %0d", i, bus.count, bus.empty, bus.full, mq.size()); end
      vectors++; if (bus.alloc_ROB !== 4'(m_tail)) begin miscompares++; $display("FAIL rnd_tail @%0d: got %0d expected %0d", i, bus.alloc_ROB, m_tail); end
      vectors++; if (bus.src1_ready !== r1 || bus.src1_value !== v1) begin miscompares++; $display("FAIL rnd_src1 @%0d: got %b/%h expected %b/%h", i, bus.src1_ready, bus.src1_value, r1, v1); end
      vectors++; if (bus.src2_ready !== r2 || bus.src2_value !== v2) begin miscompares++; $display("FAIL rnd_src2 @%0d: got %b/%h expected %b/%h", i, bus.src2_ready, bus.src2_value, r2, v2); end
      tick();
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_tail      = 0;
    rst         = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_fill();
    test_inorder_commit();
    test_full_wrap();
    test_bypass();
    test_flush();
    test_ecall_and_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry circular reorder buffer between dispatch, the common data bus (CDB) and the commit unit. Dispatch allocates entries in program order and receives a ROB tag. Execution units write results back by tag. The oldest entry is presented to commit as `head` with `rob_head_ready`/`empty`, and commit retires it with `rd_en`. A flush squashes every in-flight entry on misprediction or trap.

## Interface
Parameters:
- DEPTH, 16, number of entries (power of two)
- IDX_W, 4, tag width = log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_en  in  1  dispatch requests an entry
- alloc_entry  in  ROB_entry_t  dispatch-time fields (pc, itype, reg_dest, jalr, branch_pred, special, csr_valid_read/write, csr_write_select, ras_pointer)
- alloc_ready  in  1  entry is complete at dispatch (ecall/ebreak/mret)
- alloc_ROB  out  IDX_W  tag assigned to this cycle's allocation (= tail)
- full  out  1  no free entry
- wb_valid  in  1  CDB broadcast valid
- wb_ROB  in  IDX_W  tag being written back
- wb_value, wb_destination  in  32 each  result / secondary result (branch target, CSR old value)
- wb_branch_result  in  1  resolved branch direction
- wb_exception  in  1  instruction faulted
- wb_mcause  in  8  cause code when wb_exception
- src1_ROB, src2_ROB  in  IDX_W  operand lookup tags
- src1_ready, src2_ready  out  1  operand available
- src1_value, src2_value  out  32  operand value
- rd_en  in  1  commit dequeues head
- flush  in  1  squash all entries
- head  out  ROB_entry_t  oldest entry
- rob_head_ready  out  1  head valid and complete
- empty  out  1  no valid entries
- count  out  IDX_W+1  occupied entries

## Operation
- State: entry array, per-entry valid and ready bits, head_ptr, tail_ptr (IDX_W, wrap modulo DEPTH), count.
- Allocation accepted iff alloc_en & ~full. Writes alloc_entry to entries[tail], forces ROB_number = tail, clears value/destination/exception/mcause/branch_result, sets valid=1 and ready=alloc_ready, then tail++.
- Writeback: if wb_valid and valid[wb_ROB], write value, destination, branch_result, exception, mcause into that entry and set ready=1. A writeback to an invalid entry is ignored.
- Dequeue accepted iff rd_en & ~empty. Clears valid[head] and ready[head], then head++.
- count: +1 on an accepted alloc only, -1 on an accepted dequeue only, unchanged when both occur. full = (count==DEPTH); empty = (count==0).
- A slot freed by dequeue is not allocatable in the same cycle; full is computed from registered count only.
- Same-cycle writeback and allocation to the same index cannot legally occur (the slot is invalid). Allocation state wins.
- Same-cycle writeback and dequeue of the head: dequeue wins and the entry is freed.
- Operand lookup: srcN_ready = valid & ready of entries[srcN_ROB], with srcN_value = its value. Same-cycle bypass: if wb_valid and wb_ROB==srcN_ROB, then ready=1 and value=wb_value. An invalid entry returns ready=0, value=0.
- head = entries[head_ptr] when ~empty, else all zeros. rob_head_ready = ~empty & ready[head_ptr].
- Flush has priority over alloc, writeback and dequeue. It clears all valid/ready bits and sets head_ptr=tail_ptr=0, count=0. Entry payloads need not clear.
- Reset is identical to flush. Every output after reset: head=0, rob_head_ready=0, empty=1, full=0, count=0, alloc_ROB=0, srcN_ready=0, srcN_value=0 unless bypassed.

## Timing
- An allocation at edge N is visible at head, and in operand lookup, from cycle N+1.
- A writeback at edge N raises rob_head_ready at N+1 if the entry is the head. Operand lookup sees it in cycle N via bypass.
- Dequeue takes effect at the edge where rd_en is sampled. The next head is presented in the following cycle, so one commit per cycle is possible back-to-back.
- Flush at edge N gives empty=1 at N+1. Allocation is allowed in cycle N+1 and receives tag 0.
- All outputs are combinational from registered state, except the srcN bypass, which is combinational from wb inputs.

## Test plan
- Reset then 16 allocs without writeback -> tags 0..15 in order, full=1 at count 16, a 17th alloc is ignored with count stays 16, rob_head_ready=0.
- Alloc 3, writeback tag 1 then tag 0 (value 0xA5) -> rob_head_ready rises only after tag 0, head.value=0xA5. rd_en twice retires 0 then 1 in order.
- Full buffer with rd_en and alloc_en in the same cycle -> dequeue only, count=15, alloc ignored. Next cycle alloc gets tag 0 (wrap), tail wraps 15->0.
- Writeback tag 5 with src1_ROB=5 in the same cycle -> src1_ready=1, src1_value=wb_value. Writeback to a free tag leaves state unchanged.
- Alloc 4 with entry 2 written back with wb_exception=1, mcause=2, then flush -> empty=1, count=0 next cycle. A later alloc receives tag 0 with exception=0.
- Alloc with alloc_ready=1 (ecall) -> rob_head_ready=1 the next cycle with no writeback. rst asserted mid-stream -> all outputs return to their reset values.
